sdram_arbit_rr: RTL and testbench

Multi-channel SDRAM command arbiter that sits between the SDRAM init/read/write/refresh sub-controllers and NCH independent user ports. After a start strobe it runs initialisation, then repeatedly grants one operation at a time: auto-refresh always wins, and user read/write requests are served round-robin across channels. A watchdog aborts any operation whose end flag never arrives. It is the parametrised successor of the single-port arbiter: N channels, fairness, a selectable read/write tie-break and timeout recovery.

---
 rtl/sdram_arbit_rr.sv | 169 ++++++++++++++++
 tb/tb_sdram_arbit_rr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit_rr.sv
// sdram_arbit_rr: multi-channel SDRAM command arbiter.
// Runs initialisation after start, then grants one operation at a time.
// Refresh always wins. User channels are served round-robin.
// A watchdog aborts READ/WRITE/AREF when the end flag never arrives.
module sdram_arbit_rr #(
  parameter int NCH      = 4,
  parameter int CW       = 2,
  parameter int RD_FIRST = 1,
  parameter int TMO      = 1024,
  parameter int TW       = 11
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           flag_init_end,
  input  logic           flag_rd_end,
  input  logic           flag_wr_end,
  input  logic           flag_ref_end,
  input  logic           ref_req,
  input  logic [NCH-1:0] rd_req,
  input  logic [NCH-1:0] wr_req,
  output logic           init_en,
  output logic           rd_en,
  output logic           wr_en,
  output logic           ref_en,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  gnt_id,
  output logic           tmo_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ARBIT = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    AREF  = 3'd5
  } state_t;

  state_t         state_reg, state_next;
  logic [NCH-1:0] gnt_reg, gnt_next;
  logic [CW-1:0]  gnt_id_reg, gnt_id_next;
  logic [CW-1:0]  rr_reg, rr_next;
  logic [TW-1:0]  cnt_reg, cnt_next;
  logic           tmo_err_reg, tmo_err_next;

  // Requesting channels, and the subset at or above the rr pointer.
  logic [NCH-1:0] req_any;
  logic [NCH-1:0] req_hi;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_req
      assign req_any[gi] = rd_req[gi] | wr_req[gi];
      assign req_hi[gi]  = req_any[gi] & (CW'(gi) >= rr_reg);
    end
  endgenerate

  // Round-robin pick: lowest requester at/after the pointer, else wrap to lowest overall.
  logic          req_found;
  logic [CW-1:0] pick;
  always_comb begin
    req_found = |req_any;
    pick      = '0;
    if (|req_hi) begin
      for (int j = NCH - 1; j >= 0; j--) begin
        if (req_hi[j]) pick = CW'(j);
      end
    end else begin
      for (int j = NCH - 1; j >= 0; j--) begin
        if (req_any[j]) pick = CW'(j);
      end
    end
  end

  // Read/write decision for the picked channel, honouring the tie-break.
  logic pick_rd;
  logic pick_wr;
  logic go_read;
  always_comb begin
    pick_rd = rd_req[pick];
    pick_wr = wr_req[pick];
    if (RD_FIRST != 0) go_read = pick_rd;
    else               go_read = pick_rd & ~pick_wr;
  end

  // Watchdog expiry on the last allowed cycle of an operation.
  logic tmo_hit;
  assign tmo_hit = (TMO != 0) && (cnt_reg == TW'(TMO - 1));

  // Next-state logic; grant, pointer and watchdog updates ride along with transitions.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    rr_next      = rr_reg;
    cnt_next     = cnt_reg;
    tmo_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = INIT;
      end
      INIT: begin
        if (flag_init_end) state_next = ARBIT;
      end
      ARBIT: begin
        cnt_next = '0;
        gnt_next = '0;
        if (ref_req) begin
          state_next = AREF;
        end else if (req_found) begin
          state_next  = go_read ? READ : WRITE;
          gnt_next    = NCH'(1) << pick;
          gnt_id_next = pick;
          rr_next     = (pick == CW'(NCH - 1)) ? '0 : pick + CW'(1);
        end
      end
      READ, WRITE, AREF: begin
        if ((state_reg == READ  && flag_rd_end) ||
            (state_reg == WRITE && flag_wr_end) ||
            (state_reg == AREF  && flag_ref_end)) begin
          state_next = ARBIT;
          gnt_next   = '0;
          cnt_next   = '0;
        end else if (tmo_hit) begin
          state_next   = ARBIT;
          gnt_next     = '0;
          cnt_next     = '0;
          tmo_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      rr_reg      <= '0;
      cnt_reg     <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      rr_reg      <= rr_next;
      cnt_reg     <= cnt_next;
      tmo_err_reg <= tmo_err_next;
    end
  end

  assign init_en = (state_reg == INIT);
  assign rd_en   = (state_reg == READ);
  assign wr_en   = (state_reg == WRITE);
  assign ref_en  = (state_reg == AREF);
  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign tmo_err = tmo_err_reg;

endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Directed bench for sdram_arbit_rr: two instances share stimulus,
// one with read-first tie-break and one with write-first.
module tb_sdram_arbit_rr;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       flag_init_end = 1'b0;
  logic       flag_rd_end = 1'b0;
  logic       flag_wr_end = 1'b0;
  logic       flag_ref_end = 1'b0;
  logic       ref_req = 1'b0;
  logic [3:0] rd_req = 4'b0;
  logic [3:0] wr_req = 4'b0;

  logic       init_en, rd_en, wr_en, ref_en, tmo_err;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       w_init_en, w_rd_en, w_wr_en, w_ref_en, w_tmo_err;
  logic [3:0] w_gnt;
  logic [1:0] w_gnt_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbit_rr #(.NCH(4), .CW(2), .RD_FIRST(1), .TMO(8), .TW(4)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .flag_init_end(flag_init_end), .flag_rd_end(flag_rd_end),
    .flag_wr_end(flag_wr_end), .flag_ref_end(flag_ref_end),
    .ref_req(ref_req), .rd_req(rd_req), .wr_req(wr_req),
    .init_en(init_en), .rd_en(rd_en), .wr_en(wr_en), .ref_en(ref_en),
    .gnt(gnt), .gnt_id(gnt_id), .tmo_err(tmo_err)
  );

  sdram_arbit_rr #(.NCH(4), .CW(2), .RD_FIRST(0), .TMO(8), .TW(4)) dut_w (
    .clk(clk), .rstn(rstn), .start(start),
    .flag_init_end(flag_init_end), .flag_rd_end(flag_rd_end),
    .flag_wr_end(flag_wr_end), .flag_ref_end(flag_ref_end),
    .ref_req(ref_req), .rd_req(rd_req), .wr_req(wr_req),
    .init_en(w_init_en), .rd_en(w_rd_en), .wr_en(w_wr_en), .ref_en(w_ref_en),
    .gnt(w_gnt), .gnt_id(w_gnt_id), .tmo_err(w_tmo_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pack the main instance's status as {init,rd,wr,ref,tmo_err,gnt,gnt_id}.
  function automatic logic [31:0] st();
    return {21'b0, init_en, rd_en, wr_en, ref_en, tmo_err, gnt, gnt_id};
  endfunction

  function automatic logic [31:0] st_w();
    return {21'b0, w_init_en, w_rd_en, w_wr_en, w_ref_en, w_tmo_err, w_gnt, w_gnt_id};
  endfunction

  function automatic logic [31:0] mk(input logic i, input logic r, input logic w,
                                     input logic f, input logic t,
                                     input logic [3:0] g, input logic [1:0] id);
    return {21'b0, i, r, w, f, t, g, id};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_gnt [4];
  logic [1:0] rr_id  [4];

  initial begin
    rr_gnt[0] = 4'b0010; rr_gnt[1] = 4'b0100; rr_gnt[2] = 4'b1000; rr_gnt[3] = 4'b0001;
    rr_id[0]  = 2'd1;    rr_id[1]  = 2'd2;    rr_id[2]  = 2'd3;    rr_id[3]  = 2'd0;

    // Reset
    #2 rstn = 1'b0;
    tick(); tick();
    chk("reset_outputs", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));
    chk("reset_outputs_w", st_w(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));
    rstn = 1'b1;
    tick();
    chk("idle_no_start", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));

    // Init
    start = 1'b1;
    tick();
    chk("init_en", st(), mk(1, 0, 0, 0, 0, 4'b0, 2'd0));
    start = 1'b0;
    flag_rd_end = 1'b1;
    tick();
    chk("init_ignores_rd_end", st(), mk(1, 0, 0, 0, 0, 4'b0, 2'd0));
    flag_rd_end = 1'b0;
    flag_init_end = 1'b1;
    tick();
    chk("init_done_arbit", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));
    flag_init_end = 1'b0;
    tick();
    chk("arbit_idle", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));

    // Refresh beats user requests
    ref_req = 1'b1;
    rd_req  = 4'b1111;
    tick();
    chk("ref_priority", st(), mk(0, 0, 0, 1, 0, 4'b0, 2'd0));
    ref_req = 1'b0;
    tick();
    chk("ref_held", st(), mk(0, 0, 0, 1, 0, 4'b0, 2'd0));
    flag_ref_end = 1'b1;
    tick();
    chk("ref_end_arbit", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));
    flag_ref_end = 1'b0;
    tick();
    chk("rr_grant0", st(), mk(0, 1, 0, 0, 0, 4'b0001, 2'd0));

    // Round-robin sequence with non-matching flags ignored
    for (int k = 0; k < 4; k++) begin
      flag_wr_end  = 1'b1;
      flag_ref_end = 1'b1;
      tick();
      chk("rd_ignores_other_flags", {31'b0, rd_en}, 32'd1);
      flag_wr_end  = 1'b0;
      flag_ref_end = 1'b0;
      tick();
      flag_rd_end = 1'b1;
      tick();
      chk("rd_end_arbit", st(), mk(0, 0, 0, 0, 0, 4'b0, (k == 0) ? 2'd0 : rr_id[k-1]));
      flag_rd_end = 1'b0;
      tick();
      chk("rr_grant", st(), mk(0, 1, 0, 0, 0, rr_gnt[k], rr_id[k]));
    end

    // Committed grant: dropping the request does not abort
    rd_req = 4'b0000;
    tick();
    chk("grant_committed", st(), mk(0, 1, 0, 0, 0, 4'b0001, 2'd0));
    flag_rd_end = 1'b1;
    tick();
    flag_rd_end = 1'b0;
    chk("commit_end_arbit", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));

    // Tie-break on channel 2 (pointer is at 1)
    rd_req = 4'b0100;
    wr_req = 4'b0100;
    tick();
    chk("tie_rd_first", st(), mk(0, 1, 0, 0, 0, 4'b0100, 2'd2));
    chk("tie_wr_first", st_w(), mk(0, 0, 1, 0, 0, 4'b0100, 2'd2));
    rd_req = 4'b0000;
    wr_req = 4'b0000;
    flag_rd_end = 1'b1;
    flag_wr_end = 1'b1;
    tick();
    flag_rd_end = 1'b0;
    flag_wr_end = 1'b0;
    chk("tie_end", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd2));
    chk("tie_end_w", st_w(), mk(0, 0, 0, 0, 0, 4'b0, 2'd2));

    // Watchdog expiry: pointer at 3, channel 0 wins after wrap
    wr_req = 4'b0001;
    tick();
    chk("wd_grant", st(), mk(0, 0, 1, 0, 0, 4'b0001, 2'd0));
    wr_req = 4'b0000;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("wd_wr_en_high", {30'b0, wr_en, tmo_err}, 32'b10);
    end
    tick();
    chk("wd_expire", st(), mk(0, 0, 0, 0, 1, 4'b0, 2'd0));
    chk("wd_expire_w", st_w(), mk(0, 0, 0, 0, 1, 4'b0, 2'd0));
    tick();
    chk("wd_err_pulse", {31'b0, tmo_err}, 32'd0);

    // End flag on the expiry cycle wins
    wr_req = 4'b0010;
    tick();
    chk("wd2_grant", st(), mk(0, 0, 1, 0, 0, 4'b0010, 2'd1));
    wr_req = 4'b0000;
    for (int c = 2; c <= 8; c++) tick();
    chk("wd2_cycle8", {31'b0, wr_en}, 32'd1);
    flag_wr_end = 1'b1;
    tick();
    flag_wr_end = 1'b0;
    chk("wd2_no_err", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd1));

    // Reset in the middle of a read
    rd_req = 4'b0001;
    tick();
    chk("mid_rd_grant", st(), mk(0, 1, 0, 0, 0, 4'b0001, 2'd0));
    #2 rstn = 1'b0;
    #1;
    chk("async_reset", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));
    tick();
    rstn = 1'b1;
    tick(); tick();
    chk("idle_after_reset", st(), mk(0, 0, 0, 0, 0, 4'b0, 2'd0));
    start = 1'b1;
    tick();
    chk("restart_init", st(), mk(1, 0, 0, 0, 0, 4'b0, 2'd0));
    start  = 1'b0;
    rd_req = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
